noc_port_arbiter: RTL and testbench
===================================

Name: noc_port_arbiter

Overview:
- Output-port scheduler for one NoC router output. Shares that output among NUM_IN input queues using round-robin arbitration with wormhole packet locking.
- Issues pop requests to the winning queue. The queue presents its head flit show-ahead on its data output.
- Registers the popped flit into a one-entry output stage with a valid/ready handshake toward the link or crossbar.

Parameters:
- NUM_IN, 5, number of input queues competing (N/S/E/W/Local)
- FLIT_W, 16, flit width; must match queue data width

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-low reset
- q_valid_i  input  NUM_IN  queue i non-empty; its head flit is valid on q_data_i slice i
- q_data_i  input  NUM_IN*FLIT_W  head flits, queue i at bits [i*FLIT_W +: FLIT_W]
- q_pop_o  output  NUM_IN  pop request to queue i, at most one bit high
- out_valid_o  output  1  output flit valid
- out_data_o  output  FLIT_W  output flit
- out_ready_i  input  1  downstream accepts flit this cycle
- grant_o  output  NUM_IN  one-hot locked port, zero when idle
- err_o  output  1  one-cycle pulse: non-head flit discarded in IDLE

Behaviour:
- Flit type is bits [15:14]:
  - 2'b10 HEAD
  - 2'b00 BODY
  - 2'b01 TAIL
  - 2'b11 SINGLE
- Reset (rst=0, async): state=IDLE, rr_ptr=NUM_IN-1 so port 0 has first priority. q_pop_o=0, out_valid_o=0, out_data_o=0, grant_o=0, err_o=0.
- can_accept = !out_valid_o || out_ready_i. No pop occurs when can_accept=0.
- Pop cycle N:
  - q_pop_o[i]=1 combinationally.
  - At edge N+1: out_data_o<=flit, out_valid_o<=1.
  - Latency is 1 cycle; throughput is 1 flit/cycle under continuous ready.
- If out_ready_i=1 and no pop occurs, out_valid_o<=0 at the next edge. out_data_o holds its value.
- IDLE state:
  - Candidates are ports with q_valid_i=1.
  - Winner is the first candidate after rr_ptr, searching cyclically (rr_ptr+1 … rr_ptr).
  - If can_accept: pop the winner.
    - HEAD: go to LOCKED, lock=winner, grant_o=onehot(winner).
    - SINGLE: stay IDLE, rr_ptr<=winner.
    - BODY/TAIL (protocol error): flit is popped and discarded, never written to the output stage. err_o=1 next cycle. rr_ptr<=winner. Stay IDLE.
- LOCKED state:
  - Only the locked port is served; other ports are ignored.
  - If q_valid_i[lock] && can_accept: pop it.
  - If the flit is TAIL: go to IDLE, rr_ptr<=lock, grant_o<=0 at the next edge.
  - Any other type (including HEAD/SINGLE) is forwarded unchecked and the state stays LOCKED.
  - If the locked queue is empty: wait with no pops. The lock is never abandoned.
- Backpressure: out_valid_o and out_data_o stay stable while out_valid_o=1 && out_ready_i=0.
- Simultaneous pop and drain: out_ready_i=1 with out_valid_o=1 permits a same-cycle pop. The new flit replaces the old one at the edge with no bubble.
- Reset mid-packet: everything returns to reset values immediately. Upstream queues are flushed by the same reset.
- NUM_IN=1 is legal. Round-robin degenerates to always port 0.

Decomposition:
- Shared noc_pkg holds:
  - FLIT_W=16
  - typedef enum logic [1:0] flit_type_t {BODY=2'b00, TAIL=2'b01, HEAD=2'b10, SINGLE=2'b11}
  - function flit_type(flit) returning bits [15:14]
  - typedef enum {IDLE, LOCKED} arb_state_t
- Sub-module rr_arbiter (parameter N): combinational rotating-priority picker.
  - Inputs: req[N], ptr.
  - Outputs: one-hot gnt[N], index, any.
  - The FSM, pointer update and output stage stay in noc_port_arbiter.

Test Plan:
- Post-reset contention: ports 0 and 2 hold SINGLE 16'hC001/16'hC002, out_ready_i=1.
  - Required: pops port 0 then port 2 on consecutive cycles.
  - Required: out_data_o shows C001 then C002 one cycle after each pop.
  - Required: grant_o stays 0.
- Wormhole lock: port 1 sends HEAD 16'h8011, BODY 16'h0012, TAIL 16'h4013; port 3 holds SINGLE 16'hC030 throughout.
  - Required: all three port-1 flits are output contiguously.
  - Required: grant_o=5'b00010 during the packet.
  - Required: port 3 is popped only after the TAIL is popped.
- Round-robin fairness: ports 0,1,4 each queue four SINGLE flits.
  - Required: pop order 0,1,4,0,1,4,...
  - Required: no port is served twice before the others are served once.
- Backpressure: out_ready_i=0 for 3 cycles with flit 16'hC0AA in the output stage.
  - Required: out_data_o holds C0AA and q_pop_o=0 during stall.
  - Required: a pop resumes in the same cycle out_ready_i returns to 1.
- Protocol error: IDLE, port 2 head is BODY 16'h0055.
  - Required: the flit is popped and err_o pulses 1 cycle.
  - Required: out_valid_o is not asserted and the state stays IDLE.
- Async reset mid-packet: assert rst=0 between the HEAD and BODY of a port-0 packet.
  - Required: outputs clear with no clock edge, grant_o=0.
  - Required: after release, port 0 has priority again.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared NoC types: flit width, flit type encoding and the arbiter state.
package noc_pkg;

  localparam int FLIT_W = 16;

  // Flit type lives in the two MSBs of every flit.
  typedef enum logic [1:0] {
    BODY   = 2'b00,
    TAIL   = 2'b01,
    HEAD   = 2'b10,
    SINGLE = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  function automatic flit_type_t flit_type(input logic [FLIT_W-1:0] flit);
    return flit_type_t'(flit[15:14]);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: the first requester strictly after
// ptr (wrapping) wins. ptr itself has the lowest priority.
module rr_arbiter #(
  parameter  int N     = 5,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     gnt,
  output logic [PTR_W-1:0] index,
  output logic             any
);

  // Walk the ports once starting after ptr and latch the first request seen.
  always_comb begin
    logic [PTR_W-1:0] v_idx;
    gnt   = '0;
    index = '0;
    any   = 1'b0;
    v_idx = ptr;
    for (int k = 0; k < N; k++) begin
      v_idx = (v_idx == PTR_W'(N - 1)) ? '0 : v_idx + PTR_W'(1);
      if (!any && req[v_idx]) begin
        any        = 1'b1;
        gnt[v_idx] = 1'b1;
        index      = v_idx;
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Output-port scheduler: round-robin between input queues with wormhole
// locking, feeding a one-entry output register.
//
// Handshake: a flit transfers downstream on any cycle with out_valid_o=1 and
// out_ready_i=1. While out_valid_o=1 and out_ready_i=0 the output register is
// frozen. A queue pop (q_pop_o) is issued only when the output register is
// empty or being drained this cycle, so a popped flit always has a slot.
module noc_port_arbiter
  import noc_pkg::*;
#(
  parameter  int NUM_IN = 5,
  parameter  int FLIT_W = noc_pkg::FLIT_W,
  localparam int PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_IN-1:0]        q_valid_i,
  input  logic [NUM_IN*FLIT_W-1:0] q_data_i,
  output logic [NUM_IN-1:0]        q_pop_o,
  output logic                     out_valid_o,
  output logic [FLIT_W-1:0]        out_data_o,
  input  logic                     out_ready_i,
  output logic [NUM_IN-1:0]        grant_o,
  output logic                     err_o,
  output arb_state_t               dbg_state_o
);

  arb_state_t         r_state, w_state_nxt;
  logic [PTR_W-1:0]   r_rr_ptr, w_ptr_nxt;
  logic [PTR_W-1:0]   r_lock, w_lock_nxt;
  logic [NUM_IN-1:0]  r_grant, w_grant_nxt;
  logic               r_err, w_err_nxt;
  logic               r_out_valid;
  logic [FLIT_W-1:0]  r_out_data;

  logic               w_can_accept;
  logic [NUM_IN-1:0]  w_pop;
  logic [PTR_W-1:0]   w_pop_idx;
  logic               w_pop_any;
  logic [FLIT_W-1:0]  w_flit;
  flit_type_t         w_ftype;
  logic               w_load;
  logic [NUM_IN-1:0]  w_rr_gnt;
  logic [PTR_W-1:0]   w_rr_idx;
  logic               w_rr_any;

  assign w_can_accept = !r_out_valid || out_ready_i;

  rr_arbiter #(.N(NUM_IN)) u_rr (
    .req   (q_valid_i),
    .ptr   (r_rr_ptr),
    .gnt   (w_rr_gnt),
    .index (w_rr_idx),
    .any   (w_rr_any)
  );

  // Pop selection: round-robin winner when idle, only the locked port otherwise.
  always_comb begin
    w_pop     = '0;
    w_pop_idx = '0;
    if (w_can_accept) begin
      if (r_state == IDLE) begin
        if (w_rr_any) begin
          w_pop     = w_rr_gnt;
          w_pop_idx = w_rr_idx;
        end
      end else if (q_valid_i[r_lock]) begin
        w_pop[r_lock] = 1'b1;
        w_pop_idx     = r_lock;
      end
    end
  end

  assign w_pop_any = |w_pop;

  // Head-flit mux for the popped queue (show-ahead data).
  always_comb begin
    w_flit = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (w_pop[i]) w_flit = q_data_i[i*FLIT_W +: FLIT_W];
    end
  end

  assign w_ftype = flit_type(w_flit);

  // Next-state logic: packet locking, pointer update and protocol-error detection.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_rr_ptr;
    w_lock_nxt  = r_lock;
    w_grant_nxt = r_grant;
    w_err_nxt   = 1'b0;
    w_load      = 1'b0;
    if (w_pop_any) begin
      if (r_state == IDLE) begin
        case (w_ftype)
          HEAD: begin
            w_state_nxt = LOCKED;
            w_lock_nxt  = w_pop_idx;
            w_grant_nxt = w_pop;
            w_load      = 1'b1;
          end
          SINGLE: begin
            w_ptr_nxt = w_pop_idx;
            w_load    = 1'b1;
          end
          default: begin
            // Stray BODY/TAIL with no open packet: drop it and flag it.
            w_ptr_nxt = w_pop_idx;
            w_err_nxt = 1'b1;
          end
        endcase
      end else begin
        // Inside a packet everything is forwarded; only TAIL closes it.
        w_load = 1'b1;
        if (w_ftype == TAIL) begin
          w_state_nxt = IDLE;
          w_ptr_nxt   = r_lock;
          w_grant_nxt = '0;
        end
      end
    end
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_rr_ptr <= PTR_W'(NUM_IN - 1);
      r_lock   <= '0;
      r_grant  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_rr_ptr <= w_ptr_nxt;
      r_lock   <= w_lock_nxt;
      r_grant  <= w_grant_nxt;
      r_err    <= w_err_nxt;
    end
  end

  // One-entry output stage: load on pop, clear when drained without refill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_flit;
    end else if (out_ready_i) begin
      r_out_valid <= 1'b0;
    end
  end

  assign q_pop_o     = w_pop;
  assign out_valid_o = r_out_valid;
  assign out_data_o  = r_out_data;
  assign grant_o     = r_grant;
  assign err_o       = r_err;
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Bench for noc_port_arbiter: queue emulation, a transaction-level model
// checked every cycle, and directed scenarios with literal expectations.
module tb_noc_port_arbiter;
  import noc_pkg::*;

  localparam int N = 5;
  localparam int W = 16;

  // ---------------- clock / reset ----------------
  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   q_valid_i = '0;
  logic [N*W-1:0] q_data_i = '0;
  logic           out_ready_i = 1'b1;
  logic [N-1:0]   q_pop_o;
  logic           out_valid_o;
  logic [W-1:0]   out_data_o;
  logic [N-1:0]   grant_o;
  logic           err_o;
  arb_state_t     dbg_state_o;

  always #5 clk = ~clk;

  noc_port_arbiter #(.NUM_IN(N), .FLIT_W(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .q_valid_i   (q_valid_i),
    .q_data_i    (q_data_i),
    .q_pop_o     (q_pop_o),
    .out_valid_o (out_valid_o),
    .out_data_o  (out_data_o),
    .out_ready_i (out_ready_i),
    .grant_o     (grant_o),
    .err_o       (err_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- input queue emulation ----------------
  logic [W-1:0] port_q [N][$];
  logic [N-1:0] pop_seen = '0;

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      q_valid_i[i]       = (port_q[i].size() != 0);
      q_data_i[i*W +: W] = (port_q[i].size() != 0) ? port_q[i][0] : '0;
    end
  endtask

  task automatic push(input int p, input logic [W-1:0] f);
    port_q[p].push_back(f);
    refresh();
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) port_q[i].delete();
    refresh();
  endtask

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++)
        if (pop_seen[i] && port_q[i].size() != 0) void'(port_q[i].pop_front());
    end
    #1 refresh();
  end

  // ---------------- observation logs ----------------
  int           pop_log [$];
  logic [W-1:0] out_log [$];
  logic [W-1:0] exp_q   [$];
  int err_cnt, valid_cnt, locked_cnt, grant_hit_cnt, grant_any_cnt;

  task automatic clear_logs();
    pop_log.delete();
    out_log.delete();
    exp_q.delete();
    err_cnt = 0; valid_cnt = 0; locked_cnt = 0; grant_hit_cnt = 0; grant_any_cnt = 0;
  endtask

  // ---------------- behavioural model ----------------
  // Packet-level view: which port is mid-packet, who was served last, and
  // what sits in the output register.
  bit           m_locked, n_locked;
  int           m_lock, n_lock, m_ptr, n_ptr;
  bit           m_valid, n_valid, m_err, n_err;
  logic [W-1:0] m_data, n_data;

  always @(negedge clk) begin
    int           e_port;
    bit           loaded;
    logic [W-1:0] f;
    if (!rst) begin
      m_locked = 0; m_lock = 0; m_ptr = N - 1; m_valid = 0; m_data = '0; m_err = 0;
    end
    e_port = -1;
    if (rst && (!m_valid || out_ready_i)) begin
      if (!m_locked) begin
        for (int k = 1; k <= N; k++)
          if (e_port < 0 && q_valid_i[(m_ptr + k) % N]) e_port = (m_ptr + k) % N;
      end else if (q_valid_i[m_lock]) begin
        e_port = m_lock;
      end
    end
    check("q_pop_o",     32'(q_pop_o),     (e_port >= 0) ? (32'd1 << e_port) : 32'd0);
    check("out_valid_o", 32'(out_valid_o), 32'(m_valid));
    check("out_data_o",  32'(out_data_o),  32'(m_data));
    check("grant_o",     32'(grant_o),     m_locked ? (32'd1 << m_lock) : 32'd0);
    check("err_o",       32'(err_o),       32'(m_err));
    check("dbg_state_o", 32'(dbg_state_o), m_locked ? 32'(LOCKED) : 32'(IDLE));

    pop_seen = q_pop_o;
    for (int i = 0; i < N; i++) if (q_pop_o[i]) pop_log.push_back(i);
    if (out_valid_o && out_ready_i) out_log.push_back(out_data_o);
    if (err_o) err_cnt++;
    if (out_valid_o) valid_cnt++;
    if (dbg_state_o == LOCKED) locked_cnt++;
    if (grant_o == 5'b00010) grant_hit_cnt++;
    if (grant_o != '0) grant_any_cnt++;

    n_locked = m_locked; n_lock = m_lock; n_ptr = m_ptr; n_err = 0;
    n_valid = m_valid; n_data = m_data; loaded = 0; f = '0;
    if (e_port >= 0) begin
      f = q_data_i[e_port*W +: W];
      if (!m_locked) begin
        if (f[15:14] == 2'b10) begin n_locked = 1; n_lock = e_port; loaded = 1; end
        else if (f[15:14] == 2'b11) begin n_ptr = e_port; loaded = 1; end
        else begin n_ptr = e_port; n_err = 1; end
      end else begin
        loaded = 1;
        if (f[15:14] == 2'b01) begin n_locked = 0; n_ptr = m_lock; end
      end
    end
    if (loaded) begin n_valid = 1; n_data = f; end
    else if (out_ready_i) n_valid = 0;
  end

  always @(posedge clk) begin
    if (!rst) begin
      m_locked = 0; m_lock = 0; m_ptr = N - 1; m_valid = 0; m_data = '0; m_err = 0;
    end else begin
      m_locked = n_locked; m_lock = n_lock; m_ptr = n_ptr;
      m_valid = n_valid; m_data = n_data; m_err = n_err;
    end
  end

  // ---------------- log comparison helpers ----------------
  task automatic check_pops(input string name, input int exp_ports[$]);
    check({name, "_pop_count"}, 32'(pop_log.size()), 32'(exp_ports.size()));
    for (int i = 0; i < exp_ports.size() && i < pop_log.size(); i++)
      check({name, "_pop_order"}, 32'(pop_log[i]), 32'(exp_ports[i]));
  endtask

  task automatic check_outs(input string name);
    check({name, "_out_count"}, 32'(out_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < out_log.size(); i++)
      check({name, "_out_data"}, 32'(out_log[i]), 32'(exp_q[i]));
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    #1 rst = 1'b0;
    step(3);
    rst = 1'b1;

    // Post-reset contention: port 0 before port 2, no lock.
    clear_logs();
    push(0, 16'hC001);
    push(2, 16'hC002);
    step(5);
    check_pops("contention", '{0, 2});
    exp_q = '{16'hC001, 16'hC002};
    check_outs("contention");
    check("contention_grant_cycles", 32'(grant_any_cnt), 32'd0);

    // Wormhole lock: port 3 waits for the whole port-1 packet.
    clear_logs();
    push(1, 16'h8011);
    push(1, 16'h0012);
    push(1, 16'h4013);
    step(1);
    push(3, 16'hC030);
    step(7);
    check_pops("wormhole", '{1, 1, 1, 3});
    exp_q = '{16'h8011, 16'h0012, 16'h4013, 16'hC030};
    check_outs("wormhole");
    check("wormhole_grant_cycles", 32'(grant_hit_cnt), 32'd2);

    // Align the pointer on port 4, then check fairness among 0,1,4.
    push(4, 16'hC040);
    step(4);
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      push(0, 16'hC000 | 16'(k));
      push(1, 16'hC010 | 16'(k));
      push(4, 16'hC040 | 16'(k));
    end
    step(16);
    begin
      int exp_ports[$];
      for (int k = 0; k < 4; k++) begin
        exp_ports.push_back(0); exp_ports.push_back(1); exp_ports.push_back(4);
        exp_q.push_back(16'hC000 | 16'(k));
        exp_q.push_back(16'hC010 | 16'(k));
        exp_q.push_back(16'hC040 | 16'(k));
      end
      check_pops("fairness", exp_ports);
    end
    check_outs("fairness");

    // Backpressure: C0AA held for 3 stalled cycles, pop resumes with ready.
    clear_logs();
    push(0, 16'hC0AA);
    push(1, 16'hC0BB);
    step(1);
    out_ready_i = 1'b0;
    for (int s = 0; s < 3; s++) begin
      #3;
      check("stall_out_data",  32'(out_data_o),  32'hC0AA);
      check("stall_out_valid", 32'(out_valid_o), 32'd1);
      check("stall_q_pop",     32'(q_pop_o),     32'd0);
      step(1);
    end
    out_ready_i = 1'b1;
    #1;
    check("resume_q_pop", 32'(q_pop_o), 32'b00010);
    step(4);
    check_pops("backpressure", '{0, 1});
    exp_q = '{16'hC0AA, 16'hC0BB};
    check_outs("backpressure");

    // Protocol error: stray BODY is dropped with a single err pulse.
    clear_logs();
    push(2, 16'h0055);
    step(5);
    check_pops("proto_err", '{2});
    check("proto_err_pulses",      32'(err_cnt),    32'd1);
    check("proto_err_valid",       32'(valid_cnt),  32'd0);
    check("proto_err_locked_cyc",  32'(locked_cnt), 32'd0);

    // Async reset between HEAD and BODY of a port-0 packet.
    clear_logs();
    push(0, 16'h8001);
    push(0, 16'h0002);
    step(1);
    check("pre_reset_grant", 32'(grant_o),    32'b00001);
    check("pre_reset_data",  32'(out_data_o), 32'h8001);
    #2;
    rst = 1'b0;
    flush();
    #1;
    check("async_out_valid", 32'(out_valid_o), 32'd0);
    check("async_out_data",  32'(out_data_o),  32'd0);
    check("async_grant",     32'(grant_o),     32'd0);
    check("async_q_pop",     32'(q_pop_o),     32'd0);
    check("async_err",       32'(err_o),       32'd0);
    check("async_state",     32'(dbg_state_o), 32'(IDLE));
    step(2);
    rst = 1'b1;
    clear_logs();
    push(3, 16'hC0F3);
    push(0, 16'hC0F0);
    step(5);
    check_pops("post_reset", '{0, 3});
    exp_q = '{16'hC0F0, 16'hC0F3};
    check_outs("post_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
